// File: rtl/call_stack_pkg.sv
// Shared constants and sizing helpers for the call_stack block.
package call_stack_pkg;

  localparam int OVF_REJECT = 0;
  localparam int OVF_WRAP   = 1;

  // One operation per cycle, decoded from push/pop and the current occupancy.
  typedef enum logic [2:0] {
    OP_IDLE,
    OP_PUSH,
    OP_POP,
    OP_REPLACE,
    OP_PUSH_EMPTY_POP,
    OP_REJECT,
    OP_WRAP,
    OP_UNDERFLOW
  } op_e;

  function automatic int count_width(input int depth);
    return $clog2(depth + 1);
  endfunction

  function automatic int ptr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/call_stack_if.sv
// Request/response bundle between a stack user (master) and the stack (slave).
interface call_stack_if
  import call_stack_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
);

  localparam int CW = count_width(DEPTH);

  logic             push;
  logic             pop;
  logic [WIDTH-1:0] data_in;
  logic             clr_err;
  logic [WIDTH-1:0] data_out;
  logic             pop_valid;
  logic [WIDTH-1:0] top;
  logic [CW-1:0]    count;
  logic             full;
  logic             empty;
  logic             overflow;
  logic             underflow;

  modport master (
    output push, pop, data_in, clr_err,
    input  data_out, pop_valid, top, count, full, empty, overflow, underflow
  );

  modport slave (
    input  push, pop, data_in, clr_err,
    output data_out, pop_valid, top, count, full, empty, overflow, underflow
  );

endinterface

// File: rtl/call_stack_ptr.sv
// Modulo-DEPTH pointer register; wraps explicitly so DEPTH need not be a power of two.
module call_stack_ptr
  import call_stack_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int PW = ptr_width(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          inc,
  input  logic          dec,
  output logic [PW-1:0] ptr
);

  localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= '0;
    end else if (inc && !dec) begin
      ptr <= (ptr == LAST) ? '0 : ptr + PW'(1);
    end else if (dec && !inc) begin
      ptr <= (ptr == '0) ? LAST : ptr - PW'(1);
    end
  end

endmodule

// File: rtl/call_stack.sv
// Circular-buffer LIFO with registered pop data, sticky error flags and
// selectable overflow handling (reject the push or overwrite the oldest entry).
module call_stack
  import call_stack_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int DEPTH    = 4,
  parameter int OVF_MODE = OVF_REJECT
) (
  input logic         clk,
  input logic         rst,
  call_stack_if.slave bus
);

  localparam int CW = count_width(DEPTH);
  localparam int PW = ptr_width(DEPTH);
  localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

  logic [WIDTH-1:0] mem [DEPTH];

  logic [PW-1:0]    top_ptr;
  logic [PW-1:0]    base_ptr;
  logic [PW-1:0]    top_idx;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] data_out;
  logic             pop_valid;
  logic             overflow;
  logic             underflow;
  logic             full;
  logic             empty;
  op_e              op;
  logic             top_inc;
  logic             top_dec;
  logic             base_inc;
  logic             ovf_evt;
  logic             unf_evt;

  assign empty = (count == '0);
  assign full  = (count == CW'(DEPTH));

  // top_ptr is the next free slot, so the live top entry sits one below it.
  assign top_idx = (top_ptr == '0) ? LAST : top_ptr - PW'(1);

  always_comb begin
    op = OP_IDLE;
    if (bus.push && bus.pop) begin
      op = empty ? OP_PUSH_EMPTY_POP : OP_REPLACE;
    end else if (bus.push) begin
      if (!full) begin
        op = OP_PUSH;
      end else begin
        op = (OVF_MODE == OVF_WRAP) ? OP_WRAP : OP_REJECT;
      end
    end else if (bus.pop) begin
      op = empty ? OP_UNDERFLOW : OP_POP;
    end
  end

  assign top_inc  = (op == OP_PUSH) || (op == OP_PUSH_EMPTY_POP) || (op == OP_WRAP);
  assign top_dec  = (op == OP_POP);
  assign base_inc = (op == OP_WRAP);
  assign ovf_evt  = (op == OP_REJECT) || (op == OP_WRAP);
  assign unf_evt  = (op == OP_UNDERFLOW) || (op == OP_PUSH_EMPTY_POP);

  call_stack_ptr #(.DEPTH(DEPTH)) u_top_ptr (
    .clk (clk),
    .rst (rst),
    .inc (top_inc),
    .dec (top_dec),
    .ptr (top_ptr)
  );

  // The base only moves when a wrapping push evicts the oldest entry.
  call_stack_ptr #(.DEPTH(DEPTH)) u_base_ptr (
    .clk (clk),
    .rst (rst),
    .inc (base_inc),
    .dec (1'b0),
    .ptr (base_ptr)
  );

  // Storage is deliberately left unreset; empty masks stale contents on top.
  always_ff @(posedge clk) begin
    if (!rst) begin
      case (op)
        OP_PUSH, OP_PUSH_EMPTY_POP: mem[top_ptr]  <= bus.data_in;
        OP_WRAP:                    mem[base_ptr] <= bus.data_in;
        OP_REPLACE:                 mem[top_idx]  <= bus.data_in;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count     <= '0;
      data_out  <= '0;
      pop_valid <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      pop_valid <= 1'b0;
      case (op)
        OP_PUSH, OP_PUSH_EMPTY_POP: count <= count + CW'(1);
        OP_POP:                     count <= count - CW'(1);
        default: ;
      endcase
      if (op == OP_POP || op == OP_REPLACE) begin
        data_out  <= mem[top_idx];
        pop_valid <= 1'b1;
      end
      // A new error in the same cycle as clr_err wins.
      overflow  <= ovf_evt | (overflow  & ~bus.clr_err);
      underflow <= unf_evt | (underflow & ~bus.clr_err);
    end
  end

  assign bus.data_out  = data_out;
  assign bus.pop_valid = pop_valid;
  assign bus.top       = empty ? '0 : mem[top_idx];
  assign bus.count     = count;
  assign bus.full      = full;
  assign bus.empty     = empty;
  assign bus.overflow  = overflow;
  assign bus.underflow = underflow;

endmodule
